// File: rtl/hamm_serial_rx.sv
// UART-style deserialiser for 7-bit Hamming codewords with a one-entry holding register.
// Define HAMM_RX_PARITY_EN to add an even-parity bit after the data and a parity_err pulse.
module hamm_serial_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sin,
   output logic [6:0] d_hamm,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
`ifdef HAMM_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       overrun
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
`ifdef HAMM_RX_PARITY_EN
      PAR   = 3'd3,
`endif
      STOP  = 3'd4
   } state_t;

   // Handshake: d_hamm is offered while valid=1 and is consumed on any rising edge
   // where valid && ready; ready has no effect while valid=0.
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [6:0]       shreg_q, shreg_d;
   logic [6:0]       d_hamm_q, d_hamm_d;
   logic             valid_q, valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             sync1_q, sin_s_q;
   logic             bit_tick;
`ifdef HAMM_RX_PARITY_EN
   logic             par_bit_q, par_bit_d;
   logic             parity_err_q, parity_err_d;
`endif

   assign bit_tick = (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      d_hamm_d    = d_hamm_q;
      valid_d     = valid_q && !ready;
      frame_err_d = 1'b0;
      overrun_d   = overrun_q;
`ifdef HAMM_RX_PARITY_EN
      par_bit_d    = par_bit_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (!sin_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            // Re-check the line at mid start bit to reject glitches.
            if (cnt_q == CNT_HALF) begin
               cnt_d     = '0;
               bit_idx_d = 3'd0;
               state_d   = sin_s_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_tick) begin
               cnt_d = '0;
               for (int i = 0; i < 7; i++) begin
                  if (bit_idx_q == 3'(i)) shreg_d[i] = sin_s_q;
               end
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd6) begin
`ifdef HAMM_RX_PARITY_EN
                  state_d = PAR;
`else
                  state_d = STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef HAMM_RX_PARITY_EN
         PAR: begin
            if (bit_tick) begin
               cnt_d     = '0;
               par_bit_d = sin_s_q;
               state_d   = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_tick) begin
               cnt_d   = '0;
               state_d = IDLE;
               // Framing error outranks parity; either one discards the frame.
               if (!sin_s_q) begin
                  frame_err_d = 1'b1;
               end
`ifdef HAMM_RX_PARITY_EN
               else if ((^shreg_q) ^ par_bit_q) begin
                  parity_err_d = 1'b1;
               end
`endif
               else if (!valid_q || ready) begin
                  d_hamm_d = shreg_q;
                  valid_d  = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q     <= 1'b1;
         sin_s_q     <= 1'b1;
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= 3'd0;
         shreg_q     <= 7'd0;
         d_hamm_q    <= 7'd0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef HAMM_RX_PARITY_EN
         par_bit_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync1_q     <= sin;
         sin_s_q     <= sync1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         d_hamm_q    <= d_hamm_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef HAMM_RX_PARITY_EN
         par_bit_q    <= par_bit_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign d_hamm    = d_hamm_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
`ifdef HAMM_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_hamm_serial_rx.sv
// Directed bench for hamm_serial_rx: normal, false start, framing error, backpressure,
// mid-frame reset and (with HAMM_RX_PARITY_EN) parity cases.
`timescale 1ns/1ps
module tb_hamm_serial_rx;

   localparam int CPB = 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       sin   = 1'b1;
   logic       ready = 1'b0;
   logic [6:0] d_hamm;
   logic       valid;
   logic       frame_err;
   logic       overrun;
`ifdef HAMM_RX_PARITY_EN
   logic       parity_err;
   logic       par_flip = 1'b0;
`endif

   hamm_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sin       (sin),
      .d_hamm    (d_hamm),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
`ifdef HAMM_RX_PARITY_EN
      .parity_err(parity_err),
`endif
      .overrun   (overrun)
   );

   // clock / reset
   always #5 clk = ~clk;

   int         tests_run    = 0;
   int         tests_failed = 0;
   int         cyc          = 0;
   int         start_cyc    = 0;
   int         rise_cyc     = -1;
   int         fe_cnt       = 0;
   int         pe_cnt       = 0;
   logic       valid_prev   = 1'b0;
   logic [6:0] exp_q[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
`ifdef HAMM_RX_PARITY_EN
      if (parity_err) pe_cnt++;
`endif
      if (valid && !valid_prev) rise_cyc = cyc;
      valid_prev = valid;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sin   = 1'b1;
      ready = 1'b0;
      tick(2);
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic send_frame(input logic [6:0] data, input logic stop_bit);
      sin       = 1'b0;
      start_cyc = cyc;
      tick(CPB);
      for (int i = 0; i < 7; i++) begin
         sin = data[i];
         tick(CPB);
      end
`ifdef HAMM_RX_PARITY_EN
      sin = (^data) ^ par_flip;
      tick(CPB);
`endif
      sin = stop_bit;
      tick(CPB);
      sin = 1'b1;
   endtask

   // scoreboard: the word at the head of exp_q must be on d_hamm when it is accepted
   task automatic consume(input string tag);
      logic [6:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'bx;
      check({tag, "_data"}, {25'd0, d_hamm}, {25'd0, e});
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      check({tag, "_valid_drop"}, {31'd0, valid}, 32'd0);
   endtask

   initial begin
      logic [6:0] mr_word;
      mr_word = 7'b1100001;

      do_reset();
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_d_hamm", {25'd0, d_hamm}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
`ifdef HAMM_RX_PARITY_EN
      check("rst_parity_err", {31'd0, parity_err}, 32'd0);
`endif

      // normal frame, held until ready
      rise_cyc = -1;
      send_frame(7'b0011110, 1'b1);
      exp_q.push_back(7'b0011110);
      tick(2);
      check("norm_valid", {31'd0, valid}, 32'd1);
      check("norm_latency", {31'd0, (rise_cyc - start_cyc >= 137) && (rise_cyc - start_cyc <= 139)}, 32'd1);
      tick(20);
      check("norm_hold_valid", {31'd0, valid}, 32'd1);
      check("norm_hold_data", {25'd0, d_hamm}, {25'd0, 7'b0011110});
      consume("norm");

      // false start, then a clean frame
      fe_cnt = 0;
      sin = 1'b0;
      tick(4);
      sin = 1'b1;
      tick(40);
      check("fs_valid", {31'd0, valid}, 32'd0);
      check("fs_frame_err", fe_cnt, 32'd0);
      check("fs_overrun", {31'd0, overrun}, 32'd0);
      send_frame(7'b1010101, 1'b1);
      exp_q.push_back(7'b1010101);
      tick(2);
      check("after_fs_valid", {31'd0, valid}, 32'd1);
      consume("after_fs");

      // framing error
      do_reset();
      fe_cnt = 0;
      send_frame(7'b1010101, 1'b0);
      tick(20);
      check("ferr_pulse_cycles", fe_cnt, 32'd1);
      check("ferr_valid", {31'd0, valid}, 32'd0);
      check("ferr_d_hamm", {25'd0, d_hamm}, 32'd0);
      check("ferr_overrun", {31'd0, overrun}, 32'd0);

      // backpressure and overrun
      do_reset();
      send_frame(7'b0011110, 1'b1);
      exp_q.push_back(7'b0011110);
      check("bp_overrun_pre", {31'd0, overrun}, 32'd0);
      send_frame(7'b1010101, 1'b1);
      tick(5);
      check("bp_valid", {31'd0, valid}, 32'd1);
      check("bp_overrun", {31'd0, overrun}, 32'd1);
      consume("bp");
      check("bp_overrun_sticky", {31'd0, overrun}, 32'd1);

      // reset during data bit 3
      sin = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         sin = mr_word[i];
         tick(CPB);
      end
      sin = mr_word[3];
      tick(CPB / 2);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      sin   = 1'b1;
      exp_q.delete();
      check("mr_valid", {31'd0, valid}, 32'd0);
      check("mr_d_hamm", {25'd0, d_hamm}, 32'd0);
      check("mr_overrun", {31'd0, overrun}, 32'd0);
      check("mr_frame_err", {31'd0, frame_err}, 32'd0);
      fe_cnt = 0;
      tick(40);
      check("mr_no_ferr", fe_cnt, 32'd0);
      check("mr_idle_valid", {31'd0, valid}, 32'd0);
      send_frame(mr_word, 1'b1);
      exp_q.push_back(mr_word);
      tick(2);
      check("mr_clean_valid", {31'd0, valid}, 32'd1);
      consume("mr_clean");

`ifdef HAMM_RX_PARITY_EN
      do_reset();
      pe_cnt   = 0;
      fe_cnt   = 0;
      par_flip = 1'b1;
      send_frame(7'b0011110, 1'b1);
      tick(5);
      check("par_bad_pulse", pe_cnt, 32'd1);
      check("par_bad_valid", {31'd0, valid}, 32'd0);
      check("par_bad_ferr", fe_cnt, 32'd0);
      par_flip = 1'b0;
      send_frame(7'b0011110, 1'b1);
      exp_q.push_back(7'b0011110);
      tick(2);
      check("par_ok_valid", {31'd0, valid}, 32'd1);
      check("par_ok_no_pulse", pe_cnt, 32'd1);
      consume("par_ok");
      par_flip = 1'b1;
      send_frame(7'b0011110, 1'b0);
      tick(20);
      check("par_prio_ferr", fe_cnt, 32'd1);
      check("par_prio_no_perr", pe_cnt, 32'd1);
      par_flip = 1'b0;
`endif

      // final report
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hamm_serial_rx.md
Name: hamm_serial_rx

Overview:
- Receives 7-bit Hamming codewords over a single-wire, UART-style serial line and deserialises them.
- Presents each codeword on a parallel port with a valid/ready handshake.
- Sits directly upstream of the Hamming error-correction stage: its d_hamm output feeds that stage's 7-bit codeword input.
- Has a one-entry holding register, framing-error detection and overrun detection.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. Must be even and >= 4.
- HALF_BIT, CLKS_PER_BIT/2: derived, not overridable. Mid-bit sample offset used for start-bit validation.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- sin  input  1  serial line, idle high, asynchronous to clk
- d_hamm  output  7  received codeword; bit 0 is the first data bit on the line
- valid  output  1  d_hamm holds an unconsumed codeword
- ready  input  1  consumer accepts d_hamm when valid && ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  sticky: a complete frame was dropped because the holding register was full

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low. With rst_n=0 at a rising edge, the next state is:
  - FSM=IDLE, counters=0
  - d_hamm=0, valid=0, frame_err=0, overrun=0
  - synchroniser flops=1
- Reset applied mid-frame aborts the frame with no error reported.
- Input sync: sin passes through 2 flops giving sin_s. All decisions use sin_s, so there are 2 cycles of input latency.
- Frame format: start bit (0), then 7 data bits LSB first, then (PAR only if the macro is enabled), then a stop bit (1).
- FSM states: IDLE, START, DATA, PAR (macro only), STOP.
- IDLE:
  - On sin_s==0, go to START with cnt=0.
- START:
  - cnt increments each cycle.
  - At cnt==HALF_BIT-1: if sin_s==0, go to DATA with cnt=0, bit_idx=0. Otherwise it is a false start: go to IDLE with no output.
- DATA:
  - At cnt==CLKS_PER_BIT-1: shreg[bit_idx] <= sin_s, cnt=0, bit_idx increments.
  - After bit_idx==6 is sampled, go to STOP (or PAR).
  - All samples therefore land at bit centres.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample sin_s, then return to IDLE on the same edge.
  - If sin_s==0: frame_err=1 for exactly one cycle; shreg is discarded; valid and d_hamm are unchanged.
  - If sin_s==1 and the register is free (valid==0, or valid&&ready in this same cycle): d_hamm<=shreg and valid<=1 on this edge.
  - If sin_s==1 and the register is full (valid==1 && ready==0): the frame is dropped, d_hamm is unchanged, overrun<=1.
- Handshake:
  - valid falls on the edge after valid&&ready, unless a new frame loads on that same edge, in which case valid stays 1 with the new d_hamm.
  - d_hamm is stable while valid==1.
  - ready is ignored when valid==0.
- Latency: valid rises on the edge that samples the stop-bit centre, which is (2 + HALF_BIT + 8*CLKS_PER_BIT) cycles after the start-bit falling edge on sin, ±1 cycle of sync uncertainty.
- Back-to-back frames: a start bit may begin immediately after the stop-bit sample. IDLE checks sin_s on the very next cycle.
- overrun is cleared only by rst_n.
- Counter widths: cnt is $clog2(CLKS_PER_BIT) bits and bit_idx is 3 bits. No wrap-around beyond the compare values.

Optional Feature:
- Macro: HAMM_RX_PARITY_EN.
- When defined:
  - Adds output parity_err (1 bit, one-cycle pulse, reset 0).
  - Adds state PAR, which samples one even-parity bit at its centre after data bit 6.
  - The parity check is (^shreg) ^ par_bit, evaluated at the STOP sample.
  - On mismatch with a good stop bit: parity_err pulses, the frame is discarded, and valid, d_hamm and overrun are unaffected.
  - A stop-bit error takes priority: frame_err only, no parity_err.
- When undefined: no PAR state, no parity_err port, 9-bit frames.

Test Plan:
- Normal frame: CLKS_PER_BIT=16, send start, bits 0,1,1,1,1,0,0, stop -> d_hamm=7'b0011110, valid=1, held until ready=1, then valid=0 on the next edge.
- False start: sin low for 4 cycles, then high -> FSM returns to IDLE, valid, frame_err and overrun all stay 0.
- Framing error: frame 7'b1010101 with stop bit 0 -> frame_err high for exactly 1 cycle, valid=0, d_hamm=0.
- Backpressure: ready=0, send 7'b0011110 then 7'b1010101 -> d_hamm stays 7'b0011110, overrun=1. Raise ready -> valid falls next edge, overrun stays 1.
- Reset mid-frame: assert rst_n=0 for 1 cycle during data bit 3 -> all outputs 0 next cycle. A subsequent clean frame 7'b1100001 is received correctly.
- Parity (HAMM_RX_PARITY_EN): send 7'b0011110 with parity bit 1 (wrong) -> parity_err 1-cycle pulse, valid=0. Resend with parity 0 -> valid=1, d_hamm=7'b0011110.
